// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT input frame buffer.
package fft_buf_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Reverses the low w bits of v. Bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r = (r << 1) | ((v >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry valid/ready buffer (output register plus skid) for RAM read data.
module rd_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    logic                  skid_valid;
    logic                  skid_last;
    logic [DATA_WIDTH-1:0] skid_data;

    assign occupancy = 2'(out_valid) + 2'(skid_valid);

    // The producer only pushes when occupancy leaves room, so no push is refused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_last   <= skid_last;
                out_data   <= skid_data;
                skid_valid <= push;
                skid_last  <= push_last;
                skid_data  <= push_data;
            end else begin
                out_valid <= push;
                out_last  <= push && push_last;
                if (push) out_data <= push_data;
            end
        end else if (push && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_last  <= push_last;
            skid_data  <= push_data;
        end
    end

endmodule

// File: rtl/fft_frame_buffer_ctrl.sv
// FFT input frame buffer: loads a frame into the RAM, then streams it back out.
// Define FFT_BITREV_EN to scatter writes in bit-reversed address order.
module fft_frame_buffer_ctrl
    import fft_buf_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int MEM_SIZE   = 1024,
    localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  ram_enable_write,
    output logic                  ram_ctrl_write,
    output logic                  ram_enable_read,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_write,
    input  logic [DATA_WIDTH-1:0] ram_data_read
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   RD_TOTAL  = (ADDR_WIDTH + 1)'(MEM_SIZE);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic                  rd_pend;
    logic                  rd_pend_last;
    logic [1:0]            occ;
    logic [2:0]            fill;
    logic                  pop;
    logic                  last_pop;
    logic                  issue;

`ifdef FFT_BITREV_EN
    assign wr_addr = ADDR_WIDTH'(bitrev(32'(wr_cnt), ADDR_WIDTH));
`else
    assign wr_addr = wr_cnt;
`endif

    assign pop      = out_valid && out_ready;
    assign last_pop = pop && out_last;

    // Words held or in flight once this cycle's handshake retires; keep at most two.
    assign fill  = 3'(occ) + 3'(rd_pend) - 3'(pop);
    assign issue = (state == DRAIN) && (rd_cnt < RD_TOTAL) && (fill < 3'd2);

    // The RAM clears whatever it addresses when not written, so the idle address
    // is always either the next write target or a word already read out.
    always_comb begin
        in_ready         = (state == LOAD);
        ram_enable_write = 1'b0;
        ram_ctrl_write   = 1'b0;
        ram_enable_read  = 1'b0;
        ram_data_write   = '0;
        ram_addr         = rd_addr;
        frame_done       = last_pop;
        if (state == LOAD) begin
            ram_addr         = wr_addr;
            ram_enable_write = in_valid;
            ram_ctrl_write   = in_valid;
            ram_data_write   = in_data;
        end else begin
            ram_enable_read = issue;
            if (issue) ram_addr = rd_cnt[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= LOAD;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            rd_addr      <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= issue && (rd_cnt[ADDR_WIDTH-1:0] == LAST_ADDR);
            if (issue) begin
                rd_cnt  <= rd_cnt + 1'b1;
                rd_addr <= rd_cnt[ADDR_WIDTH-1:0];
            end
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST_ADDR) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state  <= LOAD;
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_pend),
        .push_last(rd_pend_last),
        .push_data(ram_data_read),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_data (out_data),
        .occupancy(occ)
    );

endmodule

// File: tb/tb_fft_frame_buffer_ctrl.sv
// Bench for fft_frame_buffer_ctrl with MEM_SIZE=8, a behavioural clear-on-idle RAM and a scoreboard.
module tb_fft_frame_buffer_ctrl;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_done;
    logic          ram_enable_write;
    logic          ram_ctrl_write;
    logic          ram_enable_read;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_write;
    logic [DW-1:0] ram_data_read = '0;

    logic [DW-1:0] ram [N];
    logic [DW-1:0] exp_q [$];
    int            n_chk = 0;
    int            n_pass = 0;

    typedef struct {
        int cnt;
        int addr;
    } addr_vec_t;

    typedef struct {
        bit gap;        // in_valid toggles 1,0,1,0 during LOAD
        bit rnd;        // random samples instead of 0..N-1
        int st;         // first stalled DRAIN cycle index
        int len;        // stall length (0 = none)
        int pct;        // out_ready probability outside the stall
        int exp_first;  // expected first out_valid cycle (Dn)
        int exp_reads;  // expected RAM reads per frame
    } vec_t;

    addr_vec_t atbl [N];
    vec_t      vecs [6];

    always #5 clk = ~clk;

    fft_frame_buffer_ctrl #(
        .DATA_WIDTH(DW),
        .MEM_SIZE  (N)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .frame_done      (frame_done),
        .ram_enable_write(ram_enable_write),
        .ram_ctrl_write  (ram_ctrl_write),
        .ram_enable_read (ram_enable_read),
        .ram_addr        (ram_addr),
        .ram_data_write  (ram_data_write),
        .ram_data_read   (ram_data_read)
    );

    // RAM: registered read, and the addressed word clears on any non-write cycle.
    always @(posedge clk) begin
        if (ram_enable_write && ram_ctrl_write) begin
            ram[ram_addr] <= ram_data_write;
        end else begin
            if (ram_enable_read) ram_data_read <= ram[ram_addr];
            ram[ram_addr] <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic load_frame(input bit gap, input bit rnd);
        logic [DW-1:0] m [N];
        logic [DW-1:0] d;
        for (int j = 0; j < N; j++) begin
            d = rnd ? DW'($urandom) : DW'(j);
            if (gap && j > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                #1;
                chk("gap_we", 32'(ram_enable_write), 0);
                chk("gap_cw", 32'(ram_ctrl_write), 0);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            #1;
            chk("ld_ready", 32'(in_ready), 1);
            chk("ld_we", 32'(ram_enable_write & ram_ctrl_write), 1);
            chk("ld_addr", 32'(ram_addr), 32'(atbl[j].addr));
            chk("ld_wdata", 32'(ram_data_write), 32'(d));
            m[atbl[j].addr] = d;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(m[k]);
    endtask

    // Starts on the negedge of D0; returns on the negedge after the final handshake.
    task automatic drain(input int st, input int len, input int pct, input int stop_after,
                         input int exp_first, input int exp_reads);
        int            reads = 0;
        int            hs = 0;
        int            first_vld = -1;
        bit            done = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        bit            stall;
        for (int d = 0; d < 200 && !done && !(stop_after > 0 && hs >= stop_after); d++) begin
            stall = (d >= st && d < st + len);
            if (stall) out_ready = 1'b0;
            else if (pct >= 100) out_ready = 1'b1;
            else out_ready = ($urandom_range(99) < pct);
            #1;
            if (d == 0) begin
                chk("d0_read", 32'(ram_enable_read), 1);
                chk("d0_addr", 32'(ram_addr), 0);
                chk("d0_in_ready", 32'(in_ready), 0);
            end
            if (d < 2) chk("early_vld", 32'(out_valid), 0);
            if (out_valid && first_vld < 0) first_vld = d;
            if (stall) begin
                if (d >= st + 2) begin
                    chk("stall_rd", 32'(ram_enable_read), 0);
                    chk("stall_addr", 32'(ram_addr), 32'(prev_addr));
                end
                if (out_valid && exp_q.size() > 0) chk("stall_hold", 32'(out_data), 32'(exp_q[0]));
                if (st == 2 && d == st + len - 1) chk("stall_reads_le2", 32'(reads <= 2), 1);
            end
            if (ram_enable_read) begin
                chk("rd_addr", 32'(ram_addr), 32'(reads % N));
                reads++;
            end
            prev_addr = ram_addr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(out_valid), 0);
                    done = 1'b1;
                end else begin
                    chk("hs_data", 32'(out_data), 32'(exp_q.pop_front()));
                    hs++;
                    chk("hs_last", 32'(out_last), 32'(exp_q.size() == 0));
                    chk("hs_done", 32'(frame_done), 32'(exp_q.size() == 0));
                    if (exp_q.size() == 0) begin
                        done = 1'b1;
                        if (pct >= 100 && len == 0) chk("last_cycle", 32'(d), N + 1);
                    end
                end
            end else begin
                chk("idle_done", 32'(frame_done), 0);
            end
            @(negedge clk);
        end
        if (stop_after == 0) begin
            chk("drain_timeout", 32'(done), 1);
            chk("first_vld", 32'(first_vld), 32'(exp_first));
            chk("read_count", 32'(reads), 32'(exp_reads));
            #1;
            chk("post_in_ready", 32'(in_ready), 1);
            chk("post_vld", 32'(out_valid), 0);
            chk("post_done", 32'(frame_done), 0);
        end
    endtask

    initial begin
        int rev [N];
`ifdef FFT_BITREV_EN
        rev = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        rev = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        for (int i = 0; i < N; i++) atbl[i] = '{cnt: i, addr: rev[i]};
        //         gap   rnd   st   len  pct  first reads
        vecs[0] = '{1'b0, 1'b0, 0,   0,  100, 2,    N};
        vecs[1] = '{1'b0, 1'b0, 2,   10, 100, 2,    N};
        vecs[2] = '{1'b1, 1'b0, 0,   0,  100, 2,    N};
        vecs[3] = '{1'b0, 1'b1, 0,   0,  50,  2,    N};
        vecs[4] = '{1'b1, 1'b1, 3,   4,  70,  2,    N};
        vecs[5] = '{1'b0, 1'b1, 0,   0,  30,  2,    N};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_we", 32'(ram_enable_write), 0);
        chk("rst_cw", 32'(ram_ctrl_write), 0);
        chk("rst_re", 32'(ram_enable_read), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_wdata", 32'(ram_data_write), 0);

        foreach (vecs[v]) begin
            load_frame(vecs[v].gap, vecs[v].rnd);
            drain(vecs[v].st, vecs[v].len, vecs[v].pct, 0, vecs[v].exp_first, vecs[v].exp_reads);
        end

        // Reset while the 4th output word is pending.
        load_frame(1'b0, 1'b1);
        drain(100, 0, 100, 3, 2, N);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_pending", 32'(out_valid), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_in_ready", 32'(in_ready), 1);
        chk("mid_out_valid", 32'(out_valid), 0);
        chk("mid_out_last", 32'(out_last), 0);
        chk("mid_frame_done", 32'(frame_done), 0);
        chk("mid_re", 32'(ram_enable_read), 0);
        chk("mid_addr", 32'(ram_addr), 0);
        load_frame(1'b0, 1'b1);
        drain(100, 0, 100, 0, 2, N);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/fft_frame_buffer_ctrl.md
# fft_frame_buffer_ctrl

Frame-buffer controller for the FFT input memory. It accepts one frame of MEM_SIZE samples on a valid/ready stream and writes them into the single-port `ram` in bit-reversed address order. It then reads the frame back in natural address order and presents it on a valid/ready output stream with a last flag. It sits directly upstream of the `ram` instance and drives all of its ports; the FFT datapath consumes its output stream.

## Interface
- DATA_WIDTH, 16: sample width.
- MEM_SIZE, 1024: frame length and RAM depth; power of two, ≥ 2.
- ADDR_WIDTH, $clog2(MEM_SIZE): RAM address width (derived).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  DATA_WIDTH  input sample.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  DATA_WIDTH  output sample.
- out_last  out  1  high with the final word of a frame.
- frame_done  out  1  one-cycle pulse when the last word handshakes.
- ram_enable_write, ram_ctrl_write, ram_enable_read  out  1  RAM controls.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data_write  out  DATA_WIDTH  RAM write data.
- ram_data_read  in  DATA_WIDTH  RAM read data, valid one cycle after ram_enable_read.

## Operation
- The RAM clears the addressed word on every cycle without a write. The invariant is that ram_addr always points at either the next unwritten write target or a word that has already been read out (captured or in flight).
- States: LOAD and DRAIN. Reset enters LOAD.
- Reset values: state=LOAD, wr_cnt=0, rd_cnt=0, in_ready=1, out_valid=0, out_last=0, out_data=0, frame_done=0, all ram_* outputs 0.
- LOAD:
  - in_ready=1.
  - ram_addr = bitrev(wr_cnt).
  - ram_enable_write = ram_ctrl_write = in_valid.
  - ram_data_write = in_data.
  - Each accepted word increments wr_cnt.
  - Accepting word MEM_SIZE−1 sets wr_cnt=0 and moves to DRAIN on the next cycle.
  - Cycles with in_valid=0 write nothing.
- DRAIN:
  - in_ready=0; writes disabled.
  - Two-entry output buffer: output register plus skid.
  - A read is issued (ram_enable_read=1, ram_addr=rd_cnt, rd_cnt++) when buffered words plus the in-flight read total < 2 after this cycle's output handshake, and rd_cnt has not yet issued MEM_SIZE reads.
  - On a cycle with no issue, ram_addr holds the last issued address.
  - Read data is captured from ram_data_read one cycle after issue.
  - out_last is set on the word read from address MEM_SIZE−1.
  - When that word handshakes: frame_done=1 for one cycle, then return to LOAD with wr_cnt=0 and rd_cnt=0.
- Output stream rules:
  - out_data, out_valid and out_last are registered.
  - A word is held stable while out_valid=1 and out_ready=0.
  - No word is dropped or duplicated.
- Bit reversal: bit i of the address equals bit ADDR_WIDTH−1−i of the counter. MEM_SIZE=2 reduces to identity.

## Timing
- Input throughput: one word per cycle; RAM write occurs in the same cycle as the handshake.
- Call the first DRAIN cycle D0.
  - First read is issued in D0.
  - ram_data_read is valid in D1 and captured at the end of D1.
  - out_valid=1 from D2.
- With out_ready held at 1, output runs at one word per cycle; the last word appears at D(MEM_SIZE+1).
- Frame turnaround: in_ready returns high the cycle after the out_last handshake.
- Reset mid-frame (either state): the next cycle shows reset values, the partial frame is discarded, and no frame_done is issued.

## Configuration
- FFT_BITREV_EN:
  - Defined: LOAD write address is bitrev(wr_cnt), so the output is in bit-reversed sample order.
  - Undefined: the write address is wr_cnt, so the output is in natural sample order.
  - All timing is identical in both builds.

## Structure
- Package `fft_buf_pkg`:
  - state typedef enum {LOAD, DRAIN}.
  - Parameterised bitrev function.
- Sub-module `rd_skid_buf`: two-entry valid/ready skid buffer carrying {last, data}, with occupancy output used for read issue.

## Test plan
- Reset: drive rst_n=0 for 2 cycles -> all outputs at reset values, in_ready=1, ram_addr=0.
- MEM_SIZE=8, FFT_BITREV_EN defined, stream samples 0..7 back-to-back, out_ready=1 -> writes at addresses 0,4,2,6,1,5,3,7; out_data sequence 0,4,2,6,1,5,3,7 from D2; out_last and frame_done on the 7.
- Same frame, out_ready=0 from D2 for 10 cycles -> out_data holds 0, at most 2 reads issued, ram_addr constant; after release the full sequence arrives with no loss or duplication.
- in_valid toggling 1,0,1,0 during LOAD -> no writes in the gap cycles; same output as the back-to-back case.
- rst_n=0 for 1 cycle while the 4th output word is pending -> next cycle state=LOAD, out_valid=0, in_ready=1, no frame_done; a fresh frame then loads correctly.
- FFT_BITREV_EN undefined, samples 0..7 -> out_data 0..7 in order.
